// File: rtl/dmem_responder_pkg.sv
// Shared constants, FSM state encoding and lane helpers for the D-side memory responder.
package dmem_responder_pkg;

    // Access size encodings on dsize; 2'b11 behaves like a word.
    localparam logic [1:0] DSIZE_B = 2'b00;
    localparam logic [1:0] DSIZE_H = 2'b01;
    localparam logic [1:0] DSIZE_W = 2'b10;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A halfword needs bit 0 clear; a word (or 2'b11) needs both low bits clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            DSIZE_B: bad = 1'b0;
            DSIZE_H: bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

    // Byte enables for an aligned access; lane 0 is bits 7:0 (little-endian).
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            DSIZE_B: be = 4'b0001 << lo;
            DSIZE_H: be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised, byte-enabled SRAM: synchronous write, combinational read.
// Each byte lane is its own array so a partial write never touches other lanes.
module dmem_sram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            // Commit this lane's byte when the write is enabled for it.
            always_ff @(posedge clk) begin
                if (i_we && i_be[gi]) begin
                    r_mem[i_addr] <= i_wdata[8*gi +: 8];
                end
            end

            assign o_rdata[8*gi +: 8] = r_mem[i_addr];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one load/store at a time, lane steering
// onto a byte-enabled SRAM, misalignment flagged with derr in the response cycle.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [1:0]  dsize,
    input  logic [31:0] input_ddata,
    output logic [31:0] output_ddata,
    output logic        dready_n,
    output logic        dbusy,
    output logic        derr
);

    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    state_t            r_state;
    logic [3:0]        r_count;
    logic [ADDR_W+1:0] r_addr;
    logic              r_write;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;

    logic [ADDR_W+1:0] w_addr;
    logic              w_write;
    logic [1:0]        w_size;
    logic [31:0]       w_wdata_in;
    logic              w_misaligned;
    logic              w_enter_resp;
    logic              w_we;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic [31:0]       w_shift;
    logic [31:0]       w_resp_data;

    // Pick the live bus in IDLE (single-cycle latency enters RESP straight from
    // the sampling edge); otherwise use the latched copy so later bus changes are ignored.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_addr     = daddr[ADDR_W+1:0];
            w_write    = dwrite;
            w_size     = dsize;
            w_wdata_in = input_ddata;
        end else begin
            w_addr     = r_addr;
            w_write    = r_write;
            w_size     = r_size;
            w_wdata_in = r_wdata;
        end
    end

    assign w_misaligned = is_misaligned(w_size, w_addr[1:0]);
    assign w_enter_resp = ((r_state == ST_IDLE) && dreq && (LATENCY == 1)) ||
                          ((r_state == ST_WAIT) && (r_count == 4'd1));
    assign w_we         = w_enter_resp && w_write && !w_misaligned;
    assign w_be         = lane_enables(w_size, w_addr[1:0]);

    // Replicate store data across lanes so the byte enables select the target lanes.
    always_comb begin
        case (w_size)
            DSIZE_B: w_wdata = {4{w_wdata_in[7:0]}};
            DSIZE_H: w_wdata = {2{w_wdata_in[15:0]}};
            default: w_wdata = w_wdata_in;
        endcase
    end

    dmem_sram #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_addr[ADDR_W+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Right-justify the selected lane(s); stores and misaligned accesses return zero.
    always_comb begin
        w_shift     = w_rdata >> {w_addr[1:0], 3'b000};
        w_resp_data = 32'h0;
        if (!w_write && !w_misaligned) begin
            case (w_size)
                DSIZE_B: w_resp_data = {24'h0, w_shift[7:0]};
                DSIZE_H: w_resp_data = {16'h0, w_shift[15:0]};
                default: w_resp_data = w_rdata;
            endcase
        end
    end

    // Request FSM with registered outputs: IDLE samples, WAIT counts down, RESP pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_wdata      <= 32'h0;
            dready_n     <= 1'b1;
            dbusy        <= 1'b0;
            derr         <= 1'b0;
            output_ddata <= 32'h0;
        end else begin
            dready_n     <= 1'b1;
            dbusy        <= 1'b0;
            derr         <= 1'b0;
            output_ddata <= 32'h0;
            case (r_state)
                ST_IDLE: begin
                    if (dreq) begin
                        r_addr  <= daddr[ADDR_W+1:0];
                        r_write <= dwrite;
                        r_size  <= dsize;
                        r_wdata <= input_ddata;
                        r_count <= LOAD_COUNT;
                        if (LATENCY > 1) begin
                            r_state <= ST_WAIT;
                            dbusy   <= 1'b1;
                        end else begin
                            r_state      <= ST_RESP;
                            dready_n     <= 1'b0;
                            derr         <= w_misaligned;
                            output_ddata <= w_resp_data;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_count == 4'd1) begin
                        r_state      <= ST_RESP;
                        dready_n     <= 1'b0;
                        derr         <= w_misaligned;
                        output_ddata <= w_resp_data;
                    end else begin
                        r_count <= r_count - 4'd1;
                        dbusy   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 3) driven by one
// request task; expected responses are queued at issue and popped on dready_n.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_a    [3];
    logic        dreq_a   [3];
    logic        dwrite_a [3];
    logic [31:0] daddr_a  [3];
    logic [1:0]  dsize_a  [3];
    logic [31:0] wdata_a  [3];
    logic [31:0] rdata_a  [3];
    logic        rdy_a    [3];
    logic        busy_a   [3];
    logic        err_a    [3];

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            dmem_responder #(
                .LATENCY (gi + 1),
                .ADDR_W  (12)
            ) u_dut (
                .clk          (clk),
                .rst          (rst_a[gi]),
                .dreq         (dreq_a[gi]),
                .dwrite       (dwrite_a[gi]),
                .daddr        (daddr_a[gi]),
                .dsize        (dsize_a[gi]),
                .input_ddata  (wdata_a[gi]),
                .output_ddata (rdata_a[gi]),
                .dready_n     (rdy_a[gi]),
                .dbusy        (busy_a[gi]),
                .derr         (err_a[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance k; response is checked against the queue.
    // hold=1 leaves dreq asserted so the next call forms a back-to-back pair.
    task automatic issue(input int k, input logic wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input logic hold);
        exp_t e;
        exp_t got;
        bit   seen;
        e.data = exp_d;
        e.err  = exp_e;
        e.lat  = k + 1;
        sb.push_back(e);
        @(negedge clk);
        chk("idle_rdy", 32'(rdy_a[k]), 32'd1);
        chk("idle_busy", 32'(busy_a[k]), 32'd0);
        dreq_a[k]   = 1'b1;
        dwrite_a[k] = wr;
        daddr_a[k]  = addr;
        dsize_a[k]  = sz;
        wdata_a[k]  = wd;
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (rdy_a[k] == 1'b0) begin
                seen = 1'b1;
                got  = sb.pop_front();
                chk("latency", 32'(n), 32'(got.lat));
                chk("rdata", rdata_a[k], got.data);
                chk("derr", 32'(err_a[k]), 32'(got.err));
                chk("resp_busy", 32'(busy_a[k]), 32'd0);
                $display("txn k=%0d wr=%0b addr=%h size=%0d wd=%h rdata=%h derr=%0b lat=%0d",
                         k, wr, addr, sz, wd, rdata_a[k], err_a[k], n);
                if (!hold) dreq_a[k] = 1'b0;
            end else begin
                chk("wait_busy", 32'(busy_a[k]), 32'd1);
            end
        end
        if (!seen) begin
            chk("timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
            dreq_a[k] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_a[k]    = 1'b0;
            dreq_a[k]   = 1'b0;
            dwrite_a[k] = 1'b0;
            daddr_a[k]  = 32'h0;
            dsize_a[k]  = 2'b00;
            wdata_a[k]  = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_rdy", 32'(rdy_a[k]), 32'd1);
            chk("rst_busy", 32'(busy_a[k]), 32'd0);
            chk("rst_err", 32'(err_a[k]), 32'd0);
            chk("rst_data", rdata_a[k], 32'h0);
            rst_a[k] = 1'b1;
        end

        // LATENCY=2: word round trip
        issue(1, 1'b1, 32'h100, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h100, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Byte stores (garbage above the byte must be ignored), then loads
        issue(1, 1'b1, 32'h200, 2'b00, 32'hAAAAAA11, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'h201, 2'b00, 32'hBBBBBB22, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'h202, 2'b00, 32'hCCCCCC33, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'h203, 2'b00, 32'hDDDDDD44, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h200, 2'b10, 32'h0, 32'h44332211, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h200, 2'b11, 32'h0, 32'h44332211, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h202, 2'b00, 32'h0, 32'h00000033, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h202, 2'b01, 32'h0, 32'h00004433, 1'b0, 1'b0);

        // Halfword store into upper lanes of an all-ones word
        issue(1, 1'b1, 32'h300, 2'b10, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'h302, 2'b01, 32'h9999ABCD, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h300, 2'b10, 32'h0, 32'hABCDFFFF, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h302, 2'b01, 32'h0, 32'h0000ABCD, 1'b0, 1'b0);

        // Misaligned accesses: flagged, zero data, memory untouched
        issue(1, 1'b0, 32'h101, 2'b10, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1, 1'b1, 32'h303, 2'b01, 32'h00001234, 32'h0, 1'b1, 1'b0);
        issue(1, 1'b1, 32'h102, 2'b10, 32'hBAD0BAD0, 32'h0, 1'b1, 1'b0);
        issue(1, 1'b0, 32'h300, 2'b10, 32'h0, 32'hABCDFFFF, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h100, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // LATENCY=1: back-to-back with dreq held, address wrap
        issue(0, 1'b1, 32'h00004010, 2'b10, 32'h5A5AA5A5, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h00000010, 2'b10, 32'h0, 32'h5A5AA5A5, 1'b0, 1'b0);
        issue(0, 1'b0, 32'h00000011, 2'b00, 32'h0, 32'h000000A5, 1'b0, 1'b0);

        // LATENCY=3: reset during WAIT discards the in-flight store
        issue(2, 1'b1, 32'h40, 2'b10, 32'h12345678, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        dreq_a[2]   = 1'b1;
        dwrite_a[2] = 1'b1;
        daddr_a[2]  = 32'h40;
        dsize_a[2]  = 2'b10;
        wdata_a[2]  = 32'hCAFEF00D;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy_a[2]), 32'd1);
        #2 rst_a[2] = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy_a[2]), 32'd0);
        chk("async_rst_rdy", 32'(rdy_a[2]), 32'd1);
        dreq_a[2] = 1'b0;
        @(negedge clk);
        rst_a[2] = 1'b1;
        issue(2, 1'b0, 32'h40, 2'b10, 32'h0, 32'h12345678, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the D-side bus driven by the MEM stage (daddr/dreq/dwrite/dsize/write data in; read data/dready_n/dbusy out).
- Services one load or store at a time with a parameterised fixed latency.
- Performs byte/halfword/word lane steering on a word-organised, byte-enabled SRAM.
- Flags misaligned accesses.
- Used as the data memory in core simulation and as the model behind the future D-cache.

Parameters:
LATENCY, 2, cycles from request sample to response cycle (legal range 1..15)
ADDR_W, 12, word-index width; array depth = 2**ADDR_W words

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
dreq  input  1  request valid; held by requester until dready_n seen low
dwrite  input  1  1 = store, 0 = load
daddr  input  32  byte address
dsize  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
input_ddata  input  32  store data, right-justified
output_ddata  output  32  load data, right-justified, zero-extended
dready_n  output  1  active-low response strobe, one cycle
dbusy  output  1  high while a sampled request is in flight
derr  output  1  misalignment flag, valid only with dready_n low

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst). While rst low: state IDLE, counter 0, dready_n=1, dbusy=0, derr=0, output_ddata=0, sampled-request registers 0. Array contents are not reset.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if dreq=1 at an edge, latch daddr, dwrite, dsize, input_ddata and load count=LATENCY-1. Next state is WAIT if LATENCY>1, else RESP. If dreq=0, stay in IDLE.
  - WAIT: dbusy=1. Decrement count each edge; when count reaches 1, go to RESP.
  - RESP: dready_n=0 for exactly this cycle; output_ddata and derr valid; dbusy=0. Always returns to IDLE.
- Timing: dreq sampled at the end of cycle 0 → dready_n low in cycle LATENCY. Back-to-back requests therefore occupy LATENCY+1 cycles each. The IDLE cycle doubles as the stall cycle in which the requester still sees dready_n=1.
- Only the latched request copy is used after sampling. Changes on dreq, daddr or input_ddata during WAIT/RESP are ignored. A dropped dreq does not abort: the response still pulses and the store still commits.
- Word index = daddr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2**ADDR_W bytes.
- Alignment: a halfword access needs daddr[0]=0; a word access needs daddr[1:0]=00. On misalignment:
  - no array write;
  - output_ddata=0;
  - derr=1 in RESP.
- Store commit: byte enables are written at the edge entering RESP, so the data is visible to a load sampled the following cycle.
  - byte: input_ddata[7:0] to lane daddr[1:0]
  - halfword: input_ddata[15:0] to lanes {daddr[1],0}+{1,0}
  - word: all four lanes
- Load: the word is read and its selected lane(s) shifted to bit 0. Upper bits are zero; sign extension is the writeback stage's responsibility.
- Store response: output_ddata=0 in RESP.
- Little-endian: byte lane 0 = bits 7:0.

Decomposition:
- define.v gains constants DSIZE_B=2'b00, DSIZE_H=2'b01, DSIZE_W=2'b10, and the FSM state encodings.
- One sub-module, dmem_sram: synchronous-write, byte-enabled, 2**ADDR_W x 32 array with a combinational read port.
- Lane steering, alignment check and FSM stay in dmem_responder.

Test Plan:
- Reset mid-WAIT (LATENCY=3; store issued, rst pulsed low in WAIT) → dbusy/dready_n return to 0/1 immediately. The store is not committed; a later load of that word returns its prior value.
- Word store 0xDEADBEEF to 0x100, then word load 0x100 (LATENCY=2) → each response has dready_n low in cycle 2 after sampling and dbusy high in cycle 1. The load returns 0xDEADBEEF with derr=0.
- Byte stores 0x11, 0x22, 0x33, 0x44 to 0x200..0x203, then word load 0x200 → 0x44332211. A byte load from 0x202 returns 0x00000033.
- Halfword store 0xABCD to 0x302 over word 0xFFFFFFFF → word load returns 0xABCDFFFF. Halfword load 0x302 returns 0x0000ABCD.
- Misaligned word load from 0x101 and misaligned halfword store to 0x303 → derr=1, output_ddata=0 in RESP. Memory is unchanged.
- LATENCY=1 back-to-back: dreq held continuously with two requests → dready_n low in cycles 1 and 3, high in cycle 2. Address wrap: store to 4*2**ADDR_W + 0x10 is readable at 0x10.
